// File: rtl/freq_m_pkg.sv
`default_nettype none
// ============================================================================
// freq_m_pkg : gate-select encoding, gate divisors and control states shared
//              by the multi-channel frequency meter.
// Rev 1.0
// ============================================================================
package freq_m_pkg;

  localparam logic [1:0] C_GATE_SEL_FULL   = 2'd0;
  localparam logic [1:0] C_GATE_SEL_DIV10  = 2'd1;
  localparam logic [1:0] C_GATE_SEL_DIV100 = 2'd2;
  localparam logic [1:0] C_GATE_SEL_RSVD   = 2'd3;

  localparam int unsigned C_GATE_DIV_FULL  = 1;
  localparam int unsigned C_GATE_DIV_10    = 10;
  localparam int unsigned C_GATE_DIV_100   = 100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A divided gate never shrinks below one cycle, so tiny GATE_CYCLES stay usable.
  function automatic int unsigned gate_len(input int unsigned base, input int unsigned div);
    return ((base / div) == 0) ? 1 : (base / div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_m_chan.sv
`default_nettype none
// ============================================================================
// freq_m_chan : one measured channel - synchroniser, rising-edge detect,
//               window edge counter and overflow flag.
// Optional macro FREQ_M_SATURATE_EN: counter holds all-ones instead of wrapping.
// Rev 1.0
// ============================================================================
module freq_m_chan #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_base,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] cnt_upd,
  output logic             ovf_upd
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   w_rise;
  logic                   w_inc;

  assign w_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign w_inc  = count_en & w_rise;

  // cnt_upd/ovf_upd include this cycle's edge so the top can latch them at the terminal edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    cnt_upd = cnt_q;
    if (w_inc) begin
`ifdef FREQ_M_SATURATE_EN
      if (!(&cnt_q)) begin
        cnt_upd = cnt_q + C_ONE;
      end
`else
      cnt_upd = cnt_q + C_ONE;
`endif
    end
    ovf_upd = ovf_q | (w_inc & (&cnt_q));
    cnt_d   = clear ? '0   : cnt_upd;
    ovf_d   = clear ? 1'b0 : ovf_upd;
  end

  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/freq_m_multi.sv
`default_nettype none
// ============================================================================
// freq_m_multi : multi-channel gated frequency meter; counts rising edges of
//                CH_NUM async inputs over a selectable gate and latches them.
// Optional macro FREQ_M_SATURATE_EN: channel counters saturate on overflow.
// Rev 1.0
// ============================================================================
module freq_m_multi
  import freq_m_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_base,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              gate_sel,
  input  logic [CH_NUM-1:0]       sig_in,
  output logic [CH_NUM*CNT_W-1:0] freq_out,
  output logic [CH_NUM-1:0]       ovf,
  output logic [1:0]              gate_used,
  output logic                    freq_valid
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [GATE_W-1:0] C_TERM_FULL  = GATE_W'(gate_len(GATE_CYCLES, C_GATE_DIV_FULL) - 1);
  localparam logic [GATE_W-1:0] C_TERM_DIV10 = GATE_W'(gate_len(GATE_CYCLES, C_GATE_DIV_10) - 1);
  localparam logic [GATE_W-1:0] C_TERM_DIV100 = GATE_W'(gate_len(GATE_CYCLES, C_GATE_DIV_100) - 1);
  localparam logic [GATE_W-1:0] C_GATE_ONE   = GATE_W'(1);

  state_e                    state_q, state_d;
  logic [GATE_W-1:0]         gate_cnt_q, gate_cnt_d;
  logic [1:0]                sel_q, sel_d;
  logic [CH_NUM*CNT_W-1:0]   freq_out_q, freq_out_d;
  logic [CH_NUM-1:0]         res_ovf_q, res_ovf_d;
  logic [1:0]                gate_used_q, gate_used_d;
  logic                      valid_q, valid_d;

  logic [GATE_W-1:0]         w_term_val;
  logic                      w_run;
  logic                      w_counting;
  logic                      w_terminal;
  logic                      w_clear;
  logic [CH_NUM*CNT_W-1:0]   w_cnt_upd;
  logic [CH_NUM-1:0]         w_ovf_upd;

  // Reserved select falls back to the full gate.
  always_comb begin
    case (sel_q)
      C_GATE_SEL_DIV10:  w_term_val = C_TERM_DIV10;
      C_GATE_SEL_DIV100: w_term_val = C_TERM_DIV100;
      default:           w_term_val = C_TERM_FULL;
    endcase
  end

  assign w_counting = (state_q == ST_RUN);
  assign w_run      = w_counting & en;
  assign w_terminal = w_run & (gate_cnt_q == w_term_val);
  // Counters restart on every window boundary and are held empty whenever not measuring.
  assign w_clear    = ~w_run | w_terminal;

  generate
    for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
      freq_m_chan #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clk_base (clk_base),
        .rst_n    (rst_n),
        .sig_in   (sig_in[k]),
        .clear    (w_clear),
        .count_en (w_counting),
        .cnt_upd  (w_cnt_upd[k*CNT_W +: CNT_W]),
        .ovf_upd  (w_ovf_upd[k])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    sel_d       = sel_q;
    freq_out_d  = freq_out_q;
    res_ovf_d   = res_ovf_q;
    gate_used_d = gate_used_q;
    valid_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_RUN;
          gate_cnt_d = '0;
          sel_d      = gate_sel;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d    = ST_IDLE;
          gate_cnt_d = '0;
        end else if (w_terminal) begin
          gate_cnt_d  = '0;
          sel_d       = gate_sel;
          freq_out_d  = w_cnt_upd;
          res_ovf_d   = w_ovf_upd;
          gate_used_d = sel_q;
          valid_d     = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + C_GATE_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gate_cnt_q  <= '0;
      sel_q       <= C_GATE_SEL_FULL;
      freq_out_q  <= '0;
      res_ovf_q   <= '0;
      gate_used_q <= 2'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      sel_q       <= sel_d;
      freq_out_q  <= freq_out_d;
      res_ovf_q   <= res_ovf_d;
      gate_used_q <= gate_used_d;
      valid_q     <= valid_d;
    end
  end

  assign freq_out   = freq_out_q;
  assign ovf        = res_ovf_q;
  assign gate_used  = gate_used_q;
  assign freq_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_m_multi.sv
`default_nettype none
// ============================================================================
// tb_freq_m_multi : randomized bench for freq_m_multi with a window-level
//                   edge-counting reference model (8-bit and 4-bit instances).
// Rev 1.0
// ============================================================================
module tb_freq_m_multi;

  localparam int GATE = 100;
  localparam int MAXC = 8192;
`ifdef FREQ_M_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk_base = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [1:0]  gate_sel = 2'd0;
  logic [1:0]  sig_in   = 2'b00;

  logic [15:0] f8;
  logic [1:0]  ovf8, gu8;
  logic        v8;
  logic [7:0]  f4;
  logic [1:0]  ovf4, gu4;
  logic        v4;

  always #5 clk_base = ~clk_base;

  freq_m_multi #(.CH_NUM(2), .CNT_W(8), .GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut8 (
    .clk_base(clk_base), .rst_n(rst_n), .en(en), .gate_sel(gate_sel), .sig_in(sig_in),
    .freq_out(f8), .ovf(ovf8), .gate_used(gu8), .freq_valid(v8));

  freq_m_multi #(.CH_NUM(2), .CNT_W(4), .GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut4 (
    .clk_base(clk_base), .rst_n(rst_n), .en(en), .gate_sel(gate_sel), .sig_in(sig_in),
    .freq_out(f4), .ovf(ovf4), .gate_used(gu4), .freq_valid(v4));

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [1:0] sig_h [0:MAXC-1];
  int         per [2] = '{-1, -1};   // >0 period, 0 random, <0 manual
  logic [1:0] man = 2'b00;

  // Reference model: current window and the result expected on the outputs.
  bit         m_run = 1'b0;
  int         m_ws  = 0;
  int         m_wn  = 0;
  logic [1:0] m_sel = 2'd0;
  bit         e_valid = 1'b0;
  int         e_cnt [2] = '{0, 0};
  logic [1:0] e_gu = 2'd0;

  function automatic int glen(input logic [1:0] s);
    case (s)
      2'd1:    return GATE / 10;
      2'd2:    return (GATE / 100 == 0) ? 1 : GATE / 100;
      default: return GATE;
    endcase
  endfunction

  function automatic int count_rises(input int ch, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (sig_h[k][ch] && !sig_h[k-1][ch]) n++;
    return n;
  endfunction

  function automatic int expw(input int n, input int w);
    int maxv;
    maxv = (1 << w) - 1;
    if (n <= maxv) return n;
    return SAT ? maxv : (n % (1 << w));
  endfunction

  // Close the current cycle in the model, advance one clock, compare, drive next inputs.
  task automatic tick();
    logic [15:0] x8;
    logic [7:0]  x4;
    logic [1:0]  xo8, xo4;
    sig_h[cyc] = rst_n ? sig_in : 2'b00;
    if (!rst_n) begin
      m_run = 1'b0; e_valid = 1'b0; e_cnt[0] = 0; e_cnt[1] = 0; e_gu = 2'd0;
    end else begin
      e_valid = 1'b0;
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1; m_ws = cyc + 1; m_wn = glen(gate_sel); m_sel = gate_sel;
        end
      end else if (!en) begin
        m_run = 1'b0;
      end else if (cyc == m_ws + m_wn - 1) begin
        e_valid = 1'b1;
        for (int ch = 0; ch < 2; ch++) e_cnt[ch] = count_rises(ch, m_ws - 2, cyc - 2);
        e_gu = m_sel;
        m_ws = cyc + 1; m_wn = glen(gate_sel); m_sel = gate_sel;
      end
    end
    @(posedge clk_base); #1;
    cyc++;
    x8  = {8'(expw(e_cnt[1], 8)), 8'(expw(e_cnt[0], 8))};
    x4  = {4'(expw(e_cnt[1], 4)), 4'(expw(e_cnt[0], 4))};
    xo8 = {e_cnt[1] > 255, e_cnt[0] > 255};
    xo4 = {e_cnt[1] > 15,  e_cnt[0] > 15};
    vectors += 6;
    if (v8 !== e_valid) begin errors++; $display("FAIL valid8 cyc=%0d got %b want %b", cyc, v8, e_valid); end
    if (f8 !== x8)      begin errors++; $display("FAIL freq8 cyc=%0d got %h want %h", cyc, f8, x8); end
    if (ovf8 !== xo8)   begin errors++; $display("FAIL ovf8 cyc=%0d got %b want %b", cyc, ovf8, xo8); end
    if (gu8 !== e_gu)   begin errors++; $display("FAIL gate_used8 cyc=%0d got %0d want %0d", cyc, gu8, e_gu); end
    if (f4 !== x4 || v4 !== e_valid || gu4 !== e_gu) begin
      errors++; $display("FAIL freq4 cyc=%0d got %h/%b/%0d want %h/%b/%0d", cyc, f4, v4, gu4, x4, e_valid, e_gu);
    end
    if (ovf4 !== xo4)   begin errors++; $display("FAIL ovf4 cyc=%0d got %b want %b", cyc, ovf4, xo4); end
    for (int ch = 0; ch < 2; ch++) begin
      if (per[ch] > 0)       sig_in[ch] = ((cyc % per[ch]) < (per[ch] / 2));
      else if (per[ch] == 0) sig_in[ch] = 1'($urandom % 2);
      else                   sig_in[ch] = man[ch];
    end
  endtask

  // Advance until a result is latched; returns cycles waited, -1 on timeout.
  task automatic wait_valid(input int bound, output int waited);
    waited = 0;
    do begin tick(); waited++; end while (!v8 && waited < bound);
    if (!v8) begin
      errors++; vectors++;
      $display("FAIL timeout waiting freq_valid after %0d cycles", bound);
      waited = -1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; per = '{-1, -1}; man = 2'b00;
    repeat (5) tick();
    vectors++;
    if ({f8, ovf8, gu8, v8, f4, ovf4, gu4, v4} !== '0) begin
      errors++; $display("FAIL reset_state got %h/%b/%0d/%b want 0", f8, ovf8, gu8, v8);
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int nvalid = 0;
    int prev = -1;
    per = '{10, 4}; gate_sel = 2'd0;
    repeat (12) tick();
    en = 1'b1;
    repeat (330) begin
      tick();
      if (v8) begin
        nvalid++; vectors++;
        if (f8 !== {8'd25, 8'd10} || ovf8 !== 2'b00 || gu8 !== 2'd0) begin
          errors++; $display("FAIL basic_result got %h/%b/%0d want 190a/00/0", f8, ovf8, gu8);
        end
        if (prev >= 0) begin
          vectors++;
          if (cyc - prev !== GATE) begin errors++; $display("FAIL basic_spacing got %0d want %0d", cyc - prev, GATE); end
        end
        prev = cyc;
      end
    end
    vectors++;
    if (nvalid !== 3) begin errors++; $display("FAIL basic_count got %0d want 3", nvalid); end
  endtask

  task automatic test_overflow();
    int w;
    logic [3:0] want4;
    want4 = SAT ? 4'd15 : 4'd9;
    per = '{4, 10};
    wait_valid(GATE + 10, w);
    wait_valid(GATE + 10, w);
    vectors++;
    if (f4[3:0] !== want4 || ovf4 !== 2'b01 || f8[7:0] !== 8'd25 || ovf8 !== 2'b00) begin
      errors++; $display("FAIL overflow got %0d/%b/%0d/%b want %0d/01/25/00", f4[3:0], ovf4, f8[7:0], ovf8, want4);
    end
  endtask

  task automatic test_gate_change();
    int w;
    per = '{2, 0};
    repeat (15) tick();
    gate_sel = 2'd1;
    wait_valid(GATE + 10, w);
    vectors++;
    if (gu8 !== 2'd0) begin errors++; $display("FAIL gate_old got %0d want 0", gu8); end
    wait_valid(GATE / 10 + 5, w);
    vectors++;
    if (w !== 10 || gu8 !== 2'd1 || f8[7:0] !== 8'd5) begin
      errors++; $display("FAIL gate_short got %0d/%0d/%0d want 10/1/5", w, gu8, f8[7:0]);
    end
    repeat (5) tick();
    gate_sel = 2'd0;
    wait_valid(GATE / 10 + 5, w);
    vectors++;
    if (w !== 5 || gu8 !== 2'd1) begin errors++; $display("FAIL gate_mid got %0d/%0d want 5/1", w, gu8); end
    wait_valid(GATE + 10, w);
    vectors++;
    if (w !== GATE || gu8 !== 2'd0 || f8[7:0] !== 8'd50) begin
      errors++; $display("FAIL gate_back got %0d/%0d/%0d want %0d/0/50", w, gu8, f8[7:0], GATE);
    end
  endtask

  task automatic test_en_drop();
    int w, e;
    logic [15:0] w1;
    per = '{10, 4}; gate_sel = 2'd0;
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1; e = cyc;
    wait_valid(GATE + 20, w);
    vectors++;
    if (cyc - e !== GATE + 1) begin errors++; $display("FAIL en_first got %0d want %0d", cyc - e, GATE + 1); end
    w1 = f8;
    repeat (50) tick();
    en = 1'b0;
    repeat (20) begin
      tick();
      vectors++;
      if (v8 !== 1'b0 || f8 !== w1) begin errors++; $display("FAIL en_hold got %b/%h want 0/%h", v8, f8, w1); end
    end
    en = 1'b1; e = cyc;
    wait_valid(GATE + 50, w);
    vectors++;
    if (cyc - e !== GATE + 1 || f8 !== {8'd25, 8'd10}) begin
      errors++; $display("FAIL en_restart got %0d/%h want %0d/190a", cyc - e, f8, GATE + 1);
    end
  endtask

  task automatic test_reset_mid();
    int w, r;
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({f8, ovf8, gu8, v8, f4, ovf4, gu4, v4} !== '0) begin
      errors++; $display("FAIL reset_async got %h/%b/%0d/%b want 0", f8, ovf8, gu8, v8);
    end
    repeat (5) tick();
    rst_n = 1'b1; r = cyc;
    wait_valid(GATE + 50, w);
    vectors++;
    if (cyc - r !== GATE + 1) begin errors++; $display("FAIL reset_window got %0d want %0d", cyc - r, GATE + 1); end
  endtask

  task automatic test_boundary();
    int w, b;
    per = '{-1, -1}; man = 2'b00; gate_sel = 2'd1;
    wait_valid(GATE + 10, w);
    wait_valid(GATE / 10 + 5, w);
    b = cyc;
    for (int i = 1; i <= 40; i++) begin
      man[0] = ((i >= 7) && (i <= 11)) || ((i >= 28) && (i <= 32));
      tick();
      if (i % 10 == 0) begin
        vectors++;
        if (v8 !== 1'b1 || f8[7:0] !== (((i == 10) || (i == 40)) ? 8'd1 : 8'd0)) begin
          errors++; $display("FAIL boundary i=%0d got %b/%0d", i, v8, f8[7:0]);
        end
      end
    end
    vectors++;
    if (cyc - b !== 40) begin errors++; $display("FAIL boundary_len got %0d want 40", cyc - b); end
  endtask

  task automatic test_random();
    int nvalid = 0;
    per = '{0, 0};
    repeat (800) begin
      if ($urandom % 40 == 0) gate_sel = 2'($urandom % 3);
      en = ($urandom % 150 != 0);
      tick();
      if (v8) nvalid++;
    end
    en = 1'b1;
    vectors++;
    if (nvalid == 0) begin errors++; $display("FAIL random_none got 0 results want >0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_gate_change();
    test_en_drop();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
